// File: rtl/cdb_arbiter_pkg.sv
// Shared CDB definitions: bus/data types, FU tag prefixes and requester count.
// No logic, so no latency.
// No flow control lives here.
package cdb_arbiter_pkg;

  // Requester order on the CDB: 0 ALU, 1 MUL, 2 DIV, 3 LSU.
  localparam int NUM_CDB_REQ = 4;

  // Upper 5 bits of an 8-bit tag identify the functional unit.
  localparam logic [4:0] FU_ALU_TAG = 5'd1;
  localparam logic [4:0] FU_MUL_TAG = 5'd2;
  localparam logic [4:0] FU_DIV_TAG = 5'd3;
  localparam logic [4:0] FU_LSU_TAG = 5'd4;

  typedef struct packed {
    logic [7:0]  tag;
    logic [31:0] val;
  } tagged_data_t;

  typedef struct packed {
    logic        valid;
    logic [7:0]  tag;
    logic [31:0] data;
  } cdb_bus_t;

  // Pointer width for an n-way round robin; never narrower than 1 bit.
  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester/CDB bundle between the functional units and the CDB arbiter.
// No logic, so no latency.
// No backpressure: requesters hold req until they see their own grant.
interface cdb_arbiter_if
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_CDB_REQ
) ();

  logic               flush;
  logic [NUM_REQ-1:0] req_i;
  tagged_data_t       data_i [NUM_REQ];
  cdb_bus_t           cdb_o;
  logic [NUM_REQ-1:0] grant_o;
  logic               conflict_o;

  // Unit side: drives requests, watches the broadcast.
  modport master (
    output flush, req_i, data_i,
    input  cdb_o, grant_o, conflict_o
  );

  // Arbiter side.
  modport slave (
    input  flush, req_i, data_i,
    output cdb_o, grant_o, conflict_o
  );

endinterface

// File: rtl/cdb_arbiter_rr_arbiter.sv
// Rotating-priority picker: first eligible index at or after rr_ptr, with wrap.
// Combinational winner; rr_ptr advances past the winner at the clock edge.
// No backpressure; an empty eligible vector leaves rr_ptr untouched.
module rr_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N = NUM_CDB_REQ,
  localparam int PW = ptr_w(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] eligible,
  output logic [N-1:0] winner,
  output logic         any_grant
);

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] next_ptr;
  logic [N-1:0]  rot;
  logic [N-1:0]  low;

  // Rotate so rr_ptr sits at bit 0, keep the lowest set bit, rotate back.
  assign rot       = N'({eligible, eligible} >> rr_ptr);
  assign low       = rot & (~rot + N'(1));
  assign winner    = N'(({low, low} << rr_ptr) >> N);
  assign any_grant = |eligible;

  // Pointer moves to the slot just after the winner.
  always_comb begin
    next_ptr = rr_ptr;
    for (int j = 0; j < N; j++) begin
      if (winner[j]) next_ptr = PW'((j + 1) % N);
    end
  end

  // Pointer register; only a real grant moves it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           rr_ptr <= '0;
    else if (any_grant) rr_ptr <= next_ptr;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: grants one requester per cycle and registers its tag/data onto the CDB.
// One cycle: a request sampled at edge N is on cdb_o for the cycle after edge N.
// No backpressure; last owner is masked one cycle, flush suppresses the edge.
// Optional CDB_PERF_EN adds perf_busy_o / perf_conflict_o counters.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_CDB_REQ
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus
`ifdef CDB_PERF_EN
  ,
  output logic [31:0]   perf_busy_o,
  output logic [31:0]   perf_conflict_o
`endif
);

  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] winner;
  logic [NUM_REQ-1:0] grant_q;
  logic               any_grant;
  logic               multi;
  logic               conflict_q;
  tagged_data_t       win_dat;
  cdb_bus_t           cdb_q;

  // Current owner sits out one cycle so it can drop req without a duplicate beat.
  assign eligible = bus.req_i & ~grant_q & {NUM_REQ{~bus.flush}};
  assign multi    = $countones(eligible) > 1;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk       (clk),
    .rst       (rst),
    .eligible  (eligible),
    .winner    (winner),
    .any_grant (any_grant)
  );

  // One-hot select of the winner's tag/value.
  always_comb begin
    win_dat = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (winner[j]) win_dat = bus.data_i[j];
    end
  end

  // Output beat; tag/data hold on idle cycles, reset drops any beat at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cdb_q      <= '0;
      grant_q    <= '0;
      conflict_q <= 1'b0;
    end else if (any_grant) begin
      cdb_q.valid <= 1'b1;
      cdb_q.tag   <= win_dat.tag;
      cdb_q.data  <= win_dat.val;
      grant_q     <= winner;
      conflict_q  <= multi;
    end else begin
      cdb_q.valid <= 1'b0;
      grant_q     <= '0;
      conflict_q  <= 1'b0;
    end
  end

  assign bus.cdb_o      = cdb_q;
  assign bus.grant_o    = grant_q;
  assign bus.conflict_o = conflict_q;

`ifdef CDB_PERF_EN
  // Busy/conflict counters; flush already empties eligible so it never counts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_busy_o     <= '0;
      perf_conflict_o <= '0;
    end else begin
      if (any_grant) perf_busy_o <= perf_busy_o + 32'd1;
      if (multi)     perf_conflict_o <= perf_conflict_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, then random traffic vs a reference model.
// Inputs driven on negedge, outputs sampled on the following negedge.
// Requesters never stall; the table encodes the unit drop behaviour directly.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int N = NUM_CDB_REQ;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_REQ(N)) bus ();

`ifdef CDB_PERF_EN
  logic [31:0] perf_busy;
  logic [31:0] perf_conflict;
`endif

  cdb_arbiter #(.NUM_REQ(N)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus)
`ifdef CDB_PERF_EN
    ,
    .perf_busy_o     (perf_busy),
    .perf_conflict_o (perf_conflict)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Async reset with all units requesting; outputs must clear without a clock edge.
  task automatic do_reset();
    rst         = 1'b0;
    bus.flush   = 1'b0;
    bus.req_i   = '1;
    #1;
    check("rst_valid", 64'(bus.cdb_o.valid), 64'd0);
    check("rst_grant", 64'(bus.grant_o), 64'd0);
    check("rst_tag", 64'(bus.cdb_o.tag), 64'h00);
    check("rst_data", 64'(bus.cdb_o.data), 64'h0);
    check("rst_conflict", 64'(bus.conflict_o), 64'd0);
`ifdef CDB_PERF_EN
    check("rst_perf_busy", 64'(perf_busy), 64'd0);
    check("rst_perf_conflict", 64'(perf_conflict), 64'd0);
`endif
    @(negedge clk);
    check("rst_hold_grant", 64'(bus.grant_o), 64'd0);
    rst = 1'b1;
  endtask

  typedef struct {
    bit       do_rst;
    bit       flush;
    bit [3:0] req;
    bit       exp_vld;
    bit [3:0] exp_gnt;
    bit       exp_cfl;
  } vec_t;

  vec_t         tbl [15];
  logic [7:0]   fix_tag [N];
  logic [31:0]  fix_val [N];
  logic [4:0]   fu_tag  [N];

  // Reference model state.
  int           m_owner;
  int           m_ptr;
  bit           m_vld;
  bit           m_cfl;
  logic [7:0]   m_tag;
  logic [31:0]  m_dat;
  logic [31:0]  m_busy;
  logic [31:0]  m_cnt_cfl;
  logic [7:0]   r_tag [N];
  logic [31:0]  r_val [N];

  task automatic model_reset();
    m_owner   = -1;
    m_ptr     = 0;
    m_vld     = 0;
    m_cfl     = 0;
    m_tag     = 8'h00;
    m_dat     = 32'h0;
    m_busy    = 32'd0;
    m_cnt_cfl = 32'd0;
  endtask

  // One edge of the arbiter's rules: the eligible unit closest at/after the
  // pointer (cyclic distance) wins; the previous owner is skipped.
  task automatic model_step(input bit fl, input bit [3:0] rq);
    int cand[$];
    int best;
    int best_d;
    for (int k = 0; k < N; k++)
      if (rq[k] && k != m_owner && !fl) cand.push_back(k);
    if (cand.size() == 0) begin
      m_vld   = 0;
      m_owner = -1;
      m_cfl   = 0;
    end else begin
      best   = cand[0];
      best_d = N;
      foreach (cand[c]) begin
        if (((cand[c] - m_ptr + N) % N) < best_d) begin
          best_d = (cand[c] - m_ptr + N) % N;
          best   = cand[c];
        end
      end
      m_vld   = 1;
      m_owner = best;
      m_ptr   = (best + 1) % N;
      m_tag   = r_tag[best];
      m_dat   = r_val[best];
      m_cfl   = cand.size() > 1;
      m_busy  = m_busy + 32'd1;
      if (m_cfl) m_cnt_cfl = m_cnt_cfl + 32'd1;
    end
  endtask

  initial begin
    logic [7:0]  held_tag;
    logic [31:0] held_dat;
    bit [3:0]    rq;
    bit          fl;

    fu_tag  = '{FU_ALU_TAG, FU_MUL_TAG, FU_DIV_TAG, FU_LSU_TAG};
    fix_val = '{32'h0000_0011, 32'h0000_0042, 32'h0000_0033, 32'h0000_0044};
    for (int k = 0; k < N; k++) begin
      fix_tag[k]        = {fu_tag[k], 3'b010};
      bus.data_i[k].tag = fix_tag[k];
      bus.data_i[k].val = fix_val[k];
    end

    //          rst flush req      vld gnt      cfl
    tbl[0]  = '{1, 0, 4'b1111, 1, 4'b0001, 1};  // round robin, first edge after reset
    tbl[1]  = '{0, 0, 4'b1110, 1, 4'b0010, 1};
    tbl[2]  = '{0, 0, 4'b1100, 1, 4'b0100, 1};
    tbl[3]  = '{0, 0, 4'b1000, 1, 4'b1000, 0};
    tbl[4]  = '{0, 0, 4'b0000, 0, 4'b0000, 0};
    tbl[5]  = '{1, 0, 4'b0010, 1, 4'b0010, 0};  // MUL alone: 1,0,1 then reset mid-beat
    tbl[6]  = '{0, 0, 4'b0010, 0, 4'b0000, 0};
    tbl[7]  = '{0, 0, 4'b0010, 1, 4'b0010, 0};
    tbl[8]  = '{1, 1, 4'b0101, 0, 4'b0000, 0};  // flush on first edge
    tbl[9]  = '{0, 0, 4'b0101, 1, 4'b0001, 1};
    tbl[10] = '{0, 0, 4'b0101, 1, 4'b0100, 0};
    tbl[11] = '{0, 0, 4'b0101, 1, 4'b0001, 0};
    tbl[12] = '{0, 0, 4'b0101, 1, 4'b0100, 0};
    tbl[13] = '{0, 1, 4'b0101, 0, 4'b0000, 0};  // flush keeps pointer at 3
    tbl[14] = '{0, 0, 4'b0101, 1, 4'b0001, 1};

    held_tag = 8'h00;
    held_dat = 32'h0;
    for (int i = 0; i < 15; i++) begin
      if (tbl[i].do_rst) begin
        do_reset();
        held_tag = 8'h00;
        held_dat = 32'h0;
      end
      bus.flush = tbl[i].flush;
      bus.req_i = tbl[i].req;
      @(negedge clk);
      if (tbl[i].exp_vld) begin
        for (int k = 0; k < N; k++) begin
          if (tbl[i].exp_gnt[k]) begin
            held_tag = fix_tag[k];
            held_dat = fix_val[k];
          end
        end
      end
      check($sformatf("vec%0d_valid", i), 64'(bus.cdb_o.valid), 64'(tbl[i].exp_vld));
      check($sformatf("vec%0d_grant", i), 64'(bus.grant_o), 64'(tbl[i].exp_gnt));
      check($sformatf("vec%0d_conflict", i), 64'(bus.conflict_o), 64'(tbl[i].exp_cfl));
      check($sformatf("vec%0d_tag", i), 64'(bus.cdb_o.tag), 64'(held_tag));
      check($sformatf("vec%0d_data", i), 64'(bus.cdb_o.data), 64'(held_dat));
`ifdef CDB_PERF_EN
      if (i == 4) begin
        check("perf_busy_rr", 64'(perf_busy), 64'd4);
        check("perf_conflict_rr", 64'(perf_conflict), 64'd3);
      end
`endif
    end

    // Random traffic against the reference model, with one reset part-way.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc == 400) begin
        do_reset();
        model_reset();
      end
      rq = 4'($urandom);
      fl = ($urandom_range(0, 9) == 0);
      for (int k = 0; k < N; k++) begin
        r_tag[k]          = 8'($urandom);
        r_val[k]          = $urandom;
        bus.data_i[k].tag = r_tag[k];
        bus.data_i[k].val = r_val[k];
      end
      bus.flush = fl;
      bus.req_i = rq;
      model_step(fl, rq);
      @(negedge clk);
      check($sformatf("rnd%0d_valid", cyc), 64'(bus.cdb_o.valid), 64'(m_vld));
      check($sformatf("rnd%0d_grant", cyc), 64'(bus.grant_o),
            (m_owner < 0) ? 64'd0 : (64'd1 << m_owner));
      check($sformatf("rnd%0d_conflict", cyc), 64'(bus.conflict_o), 64'(m_cfl));
      check($sformatf("rnd%0d_tag", cyc), 64'(bus.cdb_o.tag), 64'(m_tag));
      check($sformatf("rnd%0d_data", cyc), 64'(bus.cdb_o.data), 64'(m_dat));
`ifdef CDB_PERF_EN
      check($sformatf("rnd%0d_perf_busy", cyc), 64'(perf_busy), 64'(m_busy));
      check($sformatf("rnd%0d_perf_conflict", cyc), 64'(perf_conflict), 64'(m_cnt_cfl));
`endif
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
